// File: rtl/uart_alici.sv
// UART receiver: recovers 8N1 frames from rx_i and writes bytes to the RX FIFO.
// Define UART_ALICI_ESLIK_EN to add an even-parity bit between the data and the stop bit.
module uart_alici #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_i,
  input  logic [15:0] baud_div_i,
  input  logic        dolu_i,
  output logic [7:0]  veri_o,
  output logic        veri_gecerli_o,
  output logic        cerceve_hatasi_o,
  output logic        tasma_o,
  output logic        eslik_hatasi_o
);

  localparam logic [2:0] BOSTA   = 3'd0;
  localparam logic [2:0] BASLA   = 3'd1;
  localparam logic [2:0] VERI_AL = 3'd2;
  localparam logic [2:0] DUR     = 3'd3;
  localparam logic [2:0] BEKLE   = 3'd4;
`ifdef UART_ALICI_ESLIK_EN
  localparam logic [2:0] ESLIK   = 3'd5;

  // Even parity: data bits plus parity bit must XOR to zero.
  function automatic logic parity_bad(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction
`endif

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] div_q, div_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  veri_q, veri_d;
  logic        vld_q, vld_d;
  logic        frm_q, frm_d;
  logic        ovf_q, ovf_d;
  logic        perr_q, perr_d;
  logic        rxs;
  logic        par_err;
  logic [15:0] half;

  assign rxs  = sync_q[SYNC_STAGES-1];
  assign half = {1'b0, div_q[15:1]};

`ifdef UART_ALICI_ESLIK_EN
  logic par_q, par_d;
  assign par_err = parity_bad(shift_q, par_q);
`else
  assign par_err = 1'b0;
`endif

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], rx_i};
    state_d = state_q;
    cnt_d   = 16'(cnt_q + 16'd1);
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    veri_d  = veri_q;
    vld_d   = 1'b0;
    frm_d   = 1'b0;
    ovf_d   = 1'b0;
    perr_d  = 1'b0;
`ifdef UART_ALICI_ESLIK_EN
    par_d   = par_q;
`endif
    case (state_q)
      BOSTA: begin
        cnt_d = 16'd0;
        if (!rxs) begin
          state_d = BASLA;
          div_d   = baud_div_i;
        end
      end
      BASLA: begin
        // Re-check the line at the middle of the start bit to reject glitches.
        if (cnt_q == half) begin
          cnt_d = 16'd0;
          if (rxs) begin
            state_d = BOSTA;
          end else begin
            state_d = VERI_AL;
            bit_d   = 3'd0;
          end
        end
      end
      VERI_AL: begin
        if (cnt_q == div_q) begin
          cnt_d   = 16'd0;
          shift_d = {rxs, shift_q[7:1]};
          bit_d   = 3'(bit_q + 3'd1);
          if (bit_q == 3'd7) begin
`ifdef UART_ALICI_ESLIK_EN
            state_d = ESLIK;
`else
            state_d = DUR;
`endif
          end
        end
      end
`ifdef UART_ALICI_ESLIK_EN
      ESLIK: begin
        if (cnt_q == div_q) begin
          cnt_d   = 16'd0;
          par_d   = rxs;
          state_d = DUR;
        end
      end
`endif
      DUR: begin
        // Leaving at mid stop bit lets the next start edge be caught immediately.
        if (cnt_q == div_q) begin
          cnt_d = 16'd0;
          if (!rxs) begin
            frm_d   = 1'b1;
            state_d = BEKLE;
          end else begin
            state_d = BOSTA;
            if (par_err) begin
              perr_d = 1'b1;
            end else if (dolu_i) begin
              ovf_d = 1'b1;
            end else begin
              vld_d  = 1'b1;
              veri_d = shift_q;
            end
          end
        end
      end
      BEKLE: begin
        cnt_d = 16'd0;
        if (rxs) state_d = BOSTA;
      end
      default: begin
        state_d = BOSTA;
        cnt_d   = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= '1;
      state_q <= BOSTA;
      cnt_q   <= 16'd0;
      div_q   <= 16'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      veri_q  <= 8'd0;
      vld_q   <= 1'b0;
      frm_q   <= 1'b0;
      ovf_q   <= 1'b0;
      perr_q  <= 1'b0;
`ifdef UART_ALICI_ESLIK_EN
      par_q   <= 1'b0;
`endif
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      veri_q  <= veri_d;
      vld_q   <= vld_d;
      frm_q   <= frm_d;
      ovf_q   <= ovf_d;
      perr_q  <= perr_d;
`ifdef UART_ALICI_ESLIK_EN
      par_q   <= par_d;
`endif
    end
  end

  assign veri_o           = veri_q;
  assign veri_gecerli_o   = vld_q;
  assign cerceve_hatasi_o = frm_q;
  assign tasma_o          = ovf_q;
  assign eslik_hatasi_o   = perr_q;

endmodule

// File: tb/tb_uart_alici.sv
// Directed bench for uart_alici: ideal-timing frames at baud_div_i=15 (16 clocks per bit).
module tb_uart_alici;

  localparam int BIT_CLKS = 16;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        rx_i;
  logic [15:0] baud_div_i;
  logic        dolu_i;
  logic [7:0]  veri_o;
  logic        veri_gecerli_o;
  logic        cerceve_hatasi_o;
  logic        tasma_o;
  logic        eslik_hatasi_o;

  int n_chk  = 0;
  int n_fail = 0;
  int n_vld  = 0;
  int n_frm  = 0;
  int n_ovf  = 0;
  int n_par  = 0;
  int b_vld, b_frm, b_ovf, b_par;
  logic [7:0] got_q[$];

  uart_alici #(.SYNC_STAGES(2)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .rx_i             (rx_i),
    .baud_div_i       (baud_div_i),
    .dolu_i           (dolu_i),
    .veri_o           (veri_o),
    .veri_gecerli_o   (veri_gecerli_o),
    .cerceve_hatasi_o (cerceve_hatasi_o),
    .tasma_o          (tasma_o),
    .eslik_hatasi_o   (eslik_hatasi_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (veri_gecerli_o) begin
      n_vld = n_vld + 1;
      got_q.push_back(veri_o);
    end
    if (cerceve_hatasi_o) n_frm = n_frm + 1;
    if (tasma_o)          n_ovf = n_ovf + 1;
    if (eslik_hatasi_o)   n_par = n_par + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (obs !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    rx_i = 1'b1;
    repeat (n) @(negedge clk_i);
  endtask

  task automatic drive_bit(input logic b);
    rx_i = b;
    repeat (BIT_CLKS) @(negedge clk_i);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_ok);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_ALICI_ESLIK_EN
    drive_bit(par_ok ? ^d : ~^d);
`endif
    drive_bit(stop);
  endtask

  task automatic snap();
    b_vld = n_vld; b_frm = n_frm; b_ovf = n_ovf; b_par = n_par;
    got_q.delete();
  endtask

  task automatic expect_counts(input string tag, input int dv, input int df, input int dov, input int dp);
    check_eq({tag, " strobes"},  n_vld - b_vld, dv);
    check_eq({tag, " framing"},  n_frm - b_frm, df);
    check_eq({tag, " overflow"}, n_ovf - b_ovf, dov);
    check_eq({tag, " parity"},   n_par - b_par, dp);
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] exp);
    check_eq({tag, " byte present"}, (got_q.size() > 0) ? 1 : 0, 1);
    if (got_q.size() > 0) check_eq({tag, " byte"}, got_q.pop_front(), exp);
  endtask

  initial begin
    rst_i      = 1'b1;
    rx_i       = 1'b1;
    dolu_i     = 1'b0;
    baud_div_i = 16'd15;
    repeat (3) @(negedge clk_i);
    check_eq("reset veri_o", veri_o, 0);
    check_eq("reset strobe", veri_gecerli_o, 0);
    check_eq("reset framing", cerceve_hatasi_o, 0);
    check_eq("reset overflow", tasma_o, 0);
    check_eq("reset parity", eslik_hatasi_o, 0);
    rst_i = 1'b0;
    idle(20);

    // 1: single clean frame
    snap();
    send_frame(8'hA5, 1'b1, 1'b1);
    idle(20);
    expect_counts("t1", 1, 0, 0, 0);
    expect_byte("t1", 8'hA5);
    check_eq("t1 veri_o held", veri_o, 8'hA5);

    // 2: back-to-back frames
    snap();
    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    send_frame(8'h3C, 1'b1, 1'b1);
    idle(20);
    expect_counts("t2", 3, 0, 0, 0);
    expect_byte("t2a", 8'h00);
    expect_byte("t2b", 8'hFF);
    expect_byte("t2c", 8'h3C);

    // 3: short glitch is a false start
    snap();
    rx_i = 1'b0;
    repeat (5) @(negedge clk_i);
    idle(40);
    expect_counts("t3 glitch", 0, 0, 0, 0);
    send_frame(8'h5A, 1'b1, 1'b1);
    idle(20);
    expect_counts("t3 frame", 1, 0, 0, 0);
    expect_byte("t3", 8'h5A);

    // 4: framing error followed by a long break
    snap();
    send_frame(8'h81, 1'b0, 1'b1);
    rx_i = 1'b0;
    repeat (500) @(negedge clk_i);
    idle(32);
    expect_counts("t4 break", 0, 1, 0, 0);
    send_frame(8'h81, 1'b1, 1'b1);
    idle(20);
    expect_counts("t4 after", 1, 1, 0, 0);
    expect_byte("t4", 8'h81);

    // 5: FIFO full drops the byte
    snap();
    dolu_i = 1'b1;
    send_frame(8'h42, 1'b1, 1'b1);
    idle(20);
    dolu_i = 1'b0;
    expect_counts("t5 full", 0, 0, 1, 0);
    check_eq("t5 veri_o unchanged", veri_o, 8'h81);
    send_frame(8'h43, 1'b1, 1'b1);
    idle(20);
    expect_counts("t5 after", 1, 0, 1, 0);
    expect_byte("t5", 8'h43);

    // 6: reset in the middle of data bit 4
    snap();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1 & (8'h99 >> i));
    rx_i = 1'b1;
    repeat (8) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check_eq("t6 veri_o after reset", veri_o, 0);
    idle(40);
    expect_counts("t6 abort", 0, 0, 0, 0);
    send_frame(8'h66, 1'b1, 1'b1);
    idle(20);
    expect_counts("t6 frame", 1, 0, 0, 0);
    expect_byte("t6", 8'h66);

`ifdef UART_ALICI_ESLIK_EN
    // parity bit wrong for 0x07
    snap();
    send_frame(8'h07, 1'b1, 1'b0);
    idle(20);
    expect_counts("t7 parity", 0, 0, 0, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_alici.md
Name: uart_alici

Overview:
UART receiver: 8N1 frames (optional parity) recovered from the asynchronous rx line and pushed as bytes into an RX FIFO through a single-cycle write strobe. Sits between the pad and the RX FIFO. Uses the same baud_div_i divisor as the transmitter, so both ends of the peripheral share one register. Reports framing, overflow and (optionally) parity errors as one-cycle pulses.

Parameters:
SYNC_STAGES, 2, number of flops in the rx_i input synchronizer (minimum 2).

Ports:
clk_i  input  1  single clock.
rst_i  input  1  synchronous reset, active-high.
rx_i  input  1  asynchronous serial line, idles high.
baud_div_i  input  16  bit period is baud_div_i+1 clocks; value must be ≥3.
dolu_i  input  1  RX FIFO full.
veri_o  output  8  received byte; registered; valid while veri_gecerli_o=1.
veri_gecerli_o  output  1  one-cycle FIFO write strobe.
cerceve_hatasi_o  output  1  one-cycle pulse: stop bit sampled low.
tasma_o  output  1  one-cycle pulse: good byte dropped because dolu_i=1.
eslik_hatasi_o  output  1  one-cycle pulse: parity mismatch (tied 0 without the optional feature).

Behaviour:
- Reset (rst_i=1 at a clock edge): state BOSTA, counter 0, shift register 0, synchronizer flops 1, veri_o=0, every strobe/pulse output 0. Reset mid-frame aborts the frame; no output pulse.
- rxs is the synchronized rx_i (SYNC_STAGES cycles of latency). All decisions use rxs only.
- At the start-edge detection, baud_div_i is latched into div_r; div_r is used for the whole frame. A change of baud_div_i mid-frame has no effect until the next frame.
- Half point h = div_r >> 1. Counter cnt is 16 bits, counts 0..div_r, reset to 0 on each bit event.
- BOSTA: rxs=0 -> BASLA, cnt=0, latch div_r.
- BASLA: at cnt==h: rxs=1 -> false start, back to BOSTA with no output; rxs=0 -> VERI_AL, cnt=0, bit index 0.
- VERI_AL: at cnt==div_r, sample rxs into the shift register LSB first. After the 8th sample -> DUR (or ESLIK when the option is on).
- DUR: at cnt==div_r, sample the stop bit.
  - rxs=1 and dolu_i=0: veri_o <= byte, veri_gecerli_o=1 on the next cycle.
  - rxs=1 and dolu_i=1: tasma_o=1 on the next cycle; veri_gecerli_o stays 0; veri_o unchanged.
  - In either rxs=1 case -> BOSTA (mid stop bit, so back-to-back frames are caught).
  - rxs=0: cerceve_hatasi_o=1 on the next cycle, byte discarded -> BEKLE.
- BEKLE: stays until rxs=1, then -> BOSTA. A break condition (line held low) therefore produces exactly one error pulse.
- dolu_i is sampled only in the stop-bit sample cycle.
- Latency: a strobe asserts exactly 1 clock after the stop-bit sample cycle. Only one of veri_gecerli_o, tasma_o, cerceve_hatasi_o and eslik_hatasi_o fires per frame.
- Sample points: mid-bit, at (h+1) + k*(div_r+1) clocks after the synchronized falling edge. Tolerates ±~4% baud mismatch at div_r≥15.

Optional Feature:
UART_ALICI_ESLIK_EN
- Defined: after 8 data bits the FSM goes to ESLIK and samples one even-parity bit at cnt==div_r, then -> DUR.
  - Parity XOR over data plus parity bit ≠ 0: the byte is dropped and eslik_hatasi_o pulses 1 cycle after the stop-bit sample, instead of veri_gecerli_o or tasma_o.
  - A framing error takes precedence over a parity error.
- Undefined: no ESLIK state; frame is 8N1; eslik_hatasi_o is constant 0.

Test Plan:
1. baud_div_i=15, send 0xA5 as 8N1 with ideal timing, dolu_i=0 -> single veri_gecerli_o pulse with veri_o=0xA5; no error pulse; state BOSTA afterwards.
2. baud_div_i=15, send 0x00, 0xFF, 0x3C back-to-back with no idle gap -> three strobes in order, values 0x00, 0xFF, 0x3C.
3. rx_i low for 5 clocks then high, baud_div_i=15 -> no output pulse; FSM back in BOSTA; a following 0x5A frame is received correctly.
4. Frame 0x81 with the stop bit driven low, then rx_i held low for 500 clocks, then high -> exactly one cerceve_hatasi_o pulse and no veri_gecerli_o; a subsequent 0x81 frame is received correctly.
5. dolu_i=1 during frame 0x42 -> tasma_o pulses once and veri_gecerli_o stays 0. Drop dolu_i and send 0x43 -> veri_o=0x43 strobe.
6. rst_i=1 for one cycle in the middle of data bit 4 of frame 0x99, then a clean 0x66 frame -> no pulse from the aborted frame; one strobe with 0x66. With UART_ALICI_ESLIK_EN defined, 0x07 sent with parity bit 0 -> eslik_hatasi_o pulses and no strobe.
